// File: rtl/shift_sequencer_reg.sv
// ---------------------------------------------------------------------------
// shift_sequencer_reg
//
// Parametrised load/shift register with a start/busy/done handshake.
// A start in IDLE either loads din (op=00), completes immediately (shift op
// with amount=0), or enters SHIFT and performs `amount` single-bit shifts,
// one per clock. Supported shifts: logical left (01), logical right (10) and
// arithmetic right (11). serial_in fills the vacated bit for LSL/LSR and
// serial_out reports the last bit shifted out, so instances can be chained.
//
// Optional feature macro: SHIFTREG_ROTATE_EN
//   When defined, LSL/LSR become rotate-left/rotate-right: the bit leaving
//   one end re-enters at the other and serial_in is ignored. ASR unchanged.
//
// Handshake: start is a request that is accepted only while the block is
// idle (busy=0). Once accepted, op/amount/din are captured and later changes
// have no effect. done pulses for exactly one cycle per accepted start and
// q holds the final result while done is high. A new start may be issued in
// the done cycle, giving back-to-back operation. busy and done are never
// high together.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   start       request pulse, sampled in IDLE only
//   op          00 load, 01 LSL, 10 LSR, 11 ASR
//   amount      number of single-bit shifts (ignored for load)
//   din         parallel load data
//   serial_in   fill bit for LSL (bit 0) and LSR (bit WIDTH-1)
//   q           register contents (registered)
//   serial_out  last bit shifted out (registered)
//   busy        high while a multi-cycle shift is in progress
//   done        one-cycle completion pulse
//   state_dbg   current FSM state (0 = IDLE, 1 = SHIFT), for observation
// ---------------------------------------------------------------------------
module shift_sequencer_reg #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [AMT_W-1:0] amount,
   input  logic [WIDTH-1:0] din,
   input  logic             serial_in,
   output logic [WIDTH-1:0] q,
   output logic             serial_out,
   output logic             busy,
   output logic             done,
   output logic             state_dbg
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_LSL  = 2'b01;
   localparam logic [1:0] OP_LSR  = 2'b10;
   localparam logic [1:0] OP_ASR  = 2'b11;

   state_t           state;
   logic [1:0]       op_r;
   logic [AMT_W-1:0] cnt;

   // One single-bit step of the captured operation, applied in SHIFT.
   logic [WIDTH-1:0] q_step;
   logic             bit_out;

   always_comb begin
      q_step  = q;
      bit_out = 1'b0;
      case (op_r)
         OP_LSL: begin
`ifdef SHIFTREG_ROTATE_EN
            q_step = {q[WIDTH-2:0], q[WIDTH-1]};
`else
            q_step = {q[WIDTH-2:0], serial_in};
`endif
            bit_out = q[WIDTH-1];
         end
         OP_LSR: begin
`ifdef SHIFTREG_ROTATE_EN
            q_step = {q[0], q[WIDTH-1:1]};
`else
            q_step = {serial_in, q[WIDTH-1:1]};
`endif
            bit_out = q[0];
         end
         OP_ASR: begin
            q_step  = {q[WIDTH-1], q[WIDTH-1:1]};
            bit_out = q[0];
         end
         default: begin
            // op_r never holds OP_LOAD in SHIFT; keep q stable if it did.
            q_step  = q;
            bit_out = serial_out;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         op_r       <= OP_LOAD;
         cnt        <= '0;
         q          <= '0;
         serial_out <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (op == OP_LOAD) begin
                     q    <= din;
                     done <= 1'b1;
                  end else if (amount == '0) begin
                     // Zero-length shift completes at once with q untouched.
                     done <= 1'b1;
                  end else begin
                     op_r  <= op;
                     cnt   <= amount;
                     busy  <= 1'b1;
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               q          <= q_step;
               serial_out <= bit_out;
               cnt        <= cnt - 1'b1;
               // cnt==1 marks the final shift; done replaces busy here so
               // the two are never high in the same cycle.
               if (cnt == {{(AMT_W-1){1'b0}}, 1'b1}) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_shift_sequencer_reg.sv
module tb_shift_sequencer_reg;

  localparam int W     = 8;
  localparam int AMT_W = 4;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [AMT_W-1:0] amount;
  logic [W-1:0]     din;
  logic             serial_in;
  logic [W-1:0]     q;
  logic             serial_out;
  logic             busy;
  logic             done;
  logic             state_dbg;

  always #5 clk = ~clk;

  shift_sequencer_reg #(.WIDTH(W), .AMT_W(AMT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .amount(amount),
    .din(din), .serial_in(serial_in), .q(q), .serial_out(serial_out),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_so_q[$];
  int           n_cmp = 0;
  int           n_err = 0;

  // Architectural model state: what q / serial_out should hold when idle.
  logic [W-1:0] cur_q  = '0;
  logic         cur_so = 1'b0;

  // Closed-form result of shifting v by n positions, where stream[i] is the
  // serial_in value present at the i-th shift edge.
  function automatic void model(input logic [1:0] mop, input int n,
                                input logic [W-1:0] v, input logic [15:0] stream,
                                output logic [W-1:0] qo, output logic so);
    longint c;
    longint st;
    int     r;
    qo = v;
    so = 1'b0;
    st = 0;
    r  = n % W;
`ifdef SHIFTREG_ROTATE_EN
    if (mop == 2'b01) begin
      c  = ((longint'(v) << r) | (longint'(v) >> (W - r)));
      qo = c[W-1:0];
      so = qo[0];
      return;
    end
    if (mop == 2'b10) begin
      c  = ((longint'(v) >> r) | (longint'(v) << (W - r)));
      qo = c[W-1:0];
      so = qo[W-1];
      return;
    end
`endif
    case (mop)
      2'b01: begin
        // {v, s0, s1, ..., s(n-1)}: low W bits remain, bit W left last.
        for (int i = 0; i < n; i++) st = st | (longint'(stream[i]) << (n - 1 - i));
        c  = (longint'(v) << n) | st;
        qo = c[W-1:0];
        so = c[W];
      end
      2'b10: begin
        // {s(n-1), ..., s1, s0, v} shifted right by n.
        for (int i = 0; i < n; i++) st = st | (longint'(stream[i]) << i);
        c  = (st << W) | longint'(v);
        qo = W'(c >> n);
        so = c[n-1];
      end
      default: begin
        c  = longint'($signed(v));
        qo = W'(c >>> n);
        so = c[n-1];
      end
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called #1 after a rising edge; returns #1 after the done edge, which is
  // also where the next start may be driven (back-to-back).
  task automatic run_op(input logic [1:0] o, input int n, input logic [W-1:0] d,
                        input int si_mode, input bit poke, input string tag);
    logic [15:0] stream;
    logic [W-1:0] eq;
    logic         eso;
    stream = '0;
    start  = 1'b1;
    op     = o;
    amount = AMT_W'(n);
    din    = d;
    @(posedge clk); #1;
    start  = 1'b0;
    op     = 2'($urandom_range(0, 3));
    amount = AMT_W'($urandom_range(0, 15));
    din    = W'($urandom);
    if (o == 2'b00) begin
      eq = d; eso = cur_so;
    end else if (n == 0) begin
      eq = cur_q; eso = cur_so;
    end else begin
      for (int i = 0; i < n; i++) begin
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          n_err++;
          $display("FAIL %s busy_phase[%0d]: busy=%b done=%b, want busy=1 done=0", tag, i, busy, done);
        end
        stream[i] = (si_mode == 0) ? 1'b0 : (si_mode == 1) ? 1'b1 : 1'($urandom);
        serial_in = stream[i];
        if (poke && i == 0) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      model(o, n, cur_q, stream, eq, eso);
    end
    exp_q.push_back(eq);
    exp_so_q.push_back(eso);
    eq  = exp_q.pop_front();
    eso = exp_so_q.pop_front();
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s handshake: done=%b busy=%b, want done=1 busy=0", tag, done, busy);
    end
    n_cmp++;
    if (q !== eq) begin
      n_err++;
      $display("FAIL %s q: got %h, want %h", tag, q, eq);
    end
    n_cmp++;
    if (serial_out !== eso) begin
      n_err++;
      $display("FAIL %s serial_out: got %b, want %b", tag, serial_out, eso);
    end
    cur_q  = eq;
    cur_so = eso;
  endtask

  task automatic check_lit(input logic [W-1:0] want, input string tag);
    n_cmp++;
    if (q !== want) begin
      n_err++;
      $display("FAIL %s literal: q=%h, want %h", tag, q, want);
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL %s idle[%0d]: done=%b busy=%b, want 0 0", tag, i, done, busy);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; start = 1'b0; op = '0; amount = '0; din = '0; serial_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (q !== '0 || busy !== 1'b0 || done !== 1'b0 || serial_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset: q=%h busy=%b done=%b so=%b, want 00 0 0 0", q, busy, done, serial_out);
    end
    reset = 1'b1;
    cur_q = '0; cur_so = 1'b0;
    idle_cycles(2, "after_reset");
  endtask

  task automatic test_load();
    run_op(2'b00, 0, 8'hA5, 0, 1'b0, "load_a5");
    check_lit(8'hA5, "load_a5");
    idle_cycles(1, "load_single_done");
  endtask

  task automatic test_plan_shifts();
`ifndef SHIFTREG_ROTATE_EN
    run_op(2'b01, 3, '0, 0, 1'b0, "lsl3");
    check_lit(8'h28, "lsl3");
    n_cmp++;
    if (serial_out !== 1'b1) begin
      n_err++;
      $display("FAIL lsl3 so_literal: got %b, want 1", serial_out);
    end
    run_op(2'b00, 0, 8'h96, 0, 1'b0, "load_96a");
    run_op(2'b11, 2, '0, 2, 1'b0, "asr2");
    check_lit(8'hE5, "asr2");
    run_op(2'b00, 0, 8'h96, 0, 1'b0, "load_96b");
    run_op(2'b10, 2, '0, 1, 1'b0, "lsr2_si1");
    check_lit(8'hE5, "lsr2_si1");
    run_op(2'b00, 0, 8'h96, 0, 1'b0, "load_96c");
    run_op(2'b10, 2, '0, 0, 1'b0, "lsr2_si0");
    check_lit(8'h25, "lsr2_si0");
`endif
  endtask

  task automatic test_boundaries();
    run_op(2'b00, 0, 8'h3C, 0, 1'b0, "load_3c");
    run_op(2'b01, 0, '0, 2, 1'b0, "amt0");
    check_lit(8'h3C, "amt0");
    run_op(2'b01, 15, '0, 1, 1'b0, "lsl15_si1");
`ifndef SHIFTREG_ROTATE_EN
    check_lit(8'hFF, "lsl15_si1");
`endif
    run_op(2'b00, 0, 8'h80, 0, 1'b0, "load_80");
    run_op(2'b11, 15, '0, 2, 1'b0, "asr15");
    check_lit(8'hFF, "asr15");
    run_op(2'b01, 4, '0, 2, 1'b1, "start_while_busy");
    idle_cycles(3, "no_extra_done");
  endtask

  task automatic test_reset_mid_shift();
    run_op(2'b00, 0, 8'h5A, 0, 1'b0, "load_5a");
    start = 1'b1; op = 2'b01; amount = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (q !== '0 || busy !== 1'b0 || done !== 1'b0 || serial_out !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: q=%h busy=%b done=%b so=%b, want 00 0 0 0", q, busy, done, serial_out);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0 || q !== '0) begin
        n_err++;
        $display("FAIL mid_reset_hold[%0d]: done=%b q=%h, want 0 00", i, done, q);
      end
    end
    reset = 1'b1;
    cur_q = '0; cur_so = 1'b0;
    idle_cycles(5, "post_reset_no_done");
    run_op(2'b00, 0, 8'hC3, 0, 1'b0, "post_reset_load");
    run_op(2'b10, 3, '0, 2, 1'b0, "post_reset_lsr");
  endtask

  task automatic test_back_to_back();
    // Each run_op begins in the previous op's done cycle.
    run_op(2'b00, 0, W'($urandom), 0, 1'b0, "b2b_load");
    run_op(2'b00, 0, W'($urandom), 0, 1'b0, "b2b_load2");
    run_op(2'b01, 1, '0, 2, 1'b0, "b2b_lsl1");
    run_op(2'b11, 2, '0, 2, 1'b0, "b2b_asr2");
    run_op(2'b10, 0, '0, 2, 1'b0, "b2b_amt0");
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      run_op(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), W'($urandom), 2,
             1'($urandom_range(0, 3) == 0), "rand");
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 2)), "rand_gap");
    end
  endtask

  task automatic test_rotate();
`ifdef SHIFTREG_ROTATE_EN
    run_op(2'b00, 0, 8'h81, 0, 1'b0, "rot_load");
    run_op(2'b01, 1, '0, 2, 1'b0, "rotl1");
    check_lit(8'h03, "rotl1");
    run_op(2'b10, 2, '0, 2, 1'b0, "rotr2");
    check_lit(8'hC0, "rotr2");
`endif
  endtask

  // ---------------- main / report ----------------
  initial begin
    test_reset();
    test_load();
    test_plan_shifts();
    test_boundaries();
    test_reset_mid_shift();
    test_back_to_back();
    test_random();
    test_rotate();
    idle_cycles(2, "final_idle");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
